// File: rtl/apb_master_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_master_if : command, response and APB master bundle for apb_master
// Rev 1.0
// ----------------------------------------------------------------------------
interface apb_master_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int SLAVE_COUNT = 3
);
  logic                   i_cmd_valid;
  logic                   o_cmd_ready;
  logic [ADDR_WIDTH-1:0]  i_cmd_addr;
  logic                   i_cmd_write;
  logic [DATA_WIDTH-1:0]  i_cmd_wdata;

  logic                   o_rsp_valid;
  logic [DATA_WIDTH-1:0]  o_rsp_rdata;
  logic                   o_rsp_err;
  logic                   o_rsp_timeout;

  logic [ADDR_WIDTH-1:0]  o_paddr;
  logic                   o_pwrite;
  logic [SLAVE_COUNT-1:0] o_psel;
  logic                   o_penable;
  logic [DATA_WIDTH-1:0]  o_pwdata;
  logic [DATA_WIDTH-1:0]  i_prdata;
  logic                   i_pready;
  logic                   i_pslverr;

  modport master (
    input  i_cmd_valid, i_cmd_addr, i_cmd_write, i_cmd_wdata,
    input  i_prdata, i_pready, i_pslverr,
    output o_cmd_ready,
    output o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
    output o_paddr, o_pwrite, o_psel, o_penable, o_pwdata
  );

  modport slave (
    output i_cmd_valid, i_cmd_addr, i_cmd_write, i_cmd_wdata,
    output i_prdata, i_pready, i_pslverr,
    input  o_cmd_ready,
    input  o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
    input  o_paddr, o_pwrite, o_psel, o_penable, o_pwdata
  );
endinterface
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_master : queued command stream to APB SETUP/ACCESS transfers
// Rev 1.0
// ----------------------------------------------------------------------------
module apb_master #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int SLAVE_COUNT = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 255
) (
  input  wire logic    i_pclk,
  input  wire logic    i_prstn,
  apb_master_if.master bus,
  output logic         o_busy
);
  localparam int SEL_BITS = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int PTR_W    = AW + 1;
  localparam int CNT_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_fifo_addr  [FIFO_DEPTH];
  logic                   r_fifo_write [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  r_fifo_wdata [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_dec_pend;

  logic [ADDR_WIDTH-1:0]  r_paddr;
  logic                   r_pwrite;
  logic [SLAVE_COUNT-1:0] r_psel;
  logic                   r_penable;
  logic [DATA_WIDTH-1:0]  r_pwdata;
  logic                   r_rsp_valid;
  logic [DATA_WIDTH-1:0]  r_rsp_rdata;
  logic                   r_rsp_err;
  logic                   r_rsp_timeout;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_load;
  logic [ADDR_WIDTH-1:0]  w_head_addr;
  logic                   w_head_write;
  logic [DATA_WIDTH-1:0]  w_head_wdata;
  logic [SEL_BITS-1:0]    w_idx;
  logic                   w_idx_ok;
  logic [SLAVE_COUNT-1:0] w_psel;
  logic [CNT_W-1:0]       w_cnt_inc;

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push  = bus.i_cmd_valid && !w_full;

  assign w_head_addr  = r_fifo_addr[r_rd_ptr[AW-1:0]];
  assign w_head_write = r_fifo_write[r_rd_ptr[AW-1:0]];
  assign w_head_wdata = r_fifo_wdata[r_rd_ptr[AW-1:0]];

  assign w_idx     = w_head_addr[ADDR_WIDTH-1 -: SEL_BITS];
  assign w_idx_ok  = int'(w_idx) < SLAVE_COUNT;
  assign w_psel    = w_idx_ok ? (SLAVE_COUNT'(1) << w_idx) : '0;
  assign w_load    = !w_empty && w_idx_ok;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // A decode-error head is only retired from IDLE so its response keeps order.
  assign w_pop = ((r_state == S_IDLE) && !w_empty) ||
                 ((r_state == S_ACCESS) && bus.i_pready && w_load);

  always_ff @(posedge i_pclk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr[AW-1:0]]  <= bus.i_cmd_addr;
      r_fifo_write[r_wr_ptr[AW-1:0]] <= bus.i_cmd_write;
      r_fifo_wdata[r_wr_ptr[AW-1:0]] <= bus.i_cmd_wdata;
    end
  end

  always_ff @(posedge i_pclk or posedge i_prstn) begin
    if (i_prstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge i_pclk or posedge i_prstn) begin
    if (i_prstn) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_dec_pend    <= 1'b0;
      r_paddr       <= '0;
      r_pwrite      <= 1'b0;
      r_psel        <= '0;
      r_penable     <= 1'b0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      // Decode errors answer one cycle after their pop, matching SETUP timing.
      r_rsp_valid   <= r_dec_pend;
      r_rsp_err     <= r_dec_pend;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
      r_dec_pend    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_paddr   <= w_head_addr;
            r_pwrite  <= w_head_write;
            r_pwdata  <= w_head_wdata;
            r_psel    <= w_psel;
            r_penable <= 1'b0;
            r_state   <= S_SETUP;
          end else begin
            r_paddr    <= '0;
            r_pwrite   <= 1'b0;
            r_pwdata   <= '0;
            r_psel     <= '0;
            r_penable  <= 1'b0;
            r_dec_pend <= !w_empty;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (bus.i_pready) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= bus.i_pslverr;
            r_rsp_rdata <= (!r_pwrite && !bus.i_pslverr) ? bus.i_prdata : '0;
            if (w_load) begin
              r_paddr   <= w_head_addr;
              r_pwrite  <= w_head_write;
              r_pwdata  <= w_head_wdata;
              r_psel    <= w_psel;
              r_penable <= 1'b0;
              r_state   <= S_SETUP;
            end else begin
              r_paddr   <= '0;
              r_pwrite  <= 1'b0;
              r_pwdata  <= '0;
              r_psel    <= '0;
              r_penable <= 1'b0;
              r_state   <= S_IDLE;
            end
          end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_paddr       <= '0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_psel        <= '0;
            r_penable     <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_psel    <= '0;
          r_penable <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_cmd_ready   = !w_full;
  assign bus.o_paddr       = r_paddr;
  assign bus.o_pwrite      = r_pwrite;
  assign bus.o_psel        = r_psel;
  assign bus.o_penable     = r_penable;
  assign bus.o_pwdata      = r_pwdata;
  assign bus.o_rsp_valid   = r_rsp_valid;
  assign bus.o_rsp_rdata   = r_rsp_rdata;
  assign bus.o_rsp_err     = r_rsp_err;
  assign bus.o_rsp_timeout = r_rsp_timeout;
  assign o_busy            = (r_state != S_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: doc/apb_master.md
# apb_master

APB requester that turns a queued command stream into APB SETUP/ACCESS transfers on one of the three master ports of the APB interconnect fabric (m0/m1/m2). Commands enter through a valid/ready interface into a small FIFO. The block decodes the slave select from the address, drives the APB master signals, and waits in ACCESS through arbitration loss and slave wait states. It returns one response per command, with error and timeout flags.

## Interface
Parameters:
- DATA_WIDTH, 32, APB data width
- ADDR_WIDTH, 32, APB address width
- SLAVE_COUNT, 3, number of slaves; SEL_BITS = $clog2(SLAVE_COUNT)
- FIFO_DEPTH, 4, command FIFO entries; must be a power of 2, ≥2
- TIMEOUT, 255, maximum ACCESS cycles without pready; counter width $clog2(TIMEOUT+1)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - i_pclk  in  1  system clock
  - i_prstn  in  1  reset, asynchronous and active-high
- Command interface:
  - i_cmd_valid  in  1  command offered
  - o_cmd_ready  out  1  FIFO not full
  - i_cmd_addr  in  ADDR_WIDTH  target address
  - i_cmd_write  in  1  1 = write, 0 = read
  - i_cmd_wdata  in  DATA_WIDTH  write data
- Response interface:
  - o_rsp_valid  out  1  one-cycle response pulse
  - o_rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for errors
  - o_rsp_err  out  1  pslverr, decode error or timeout
  - o_rsp_timeout  out  1  transfer aborted by timeout
- APB master side (to the fabric):
  - o_paddr, o_pwrite, o_psel[SLAVE_COUNT-1:0], o_penable, o_pwdata  out  APB master signals
  - i_prdata  in  DATA_WIDTH  returned read data
  - i_pready  in  1  returned ready
  - i_pslverr  in  1  returned slave error
- o_busy  out  1  FSM not IDLE, or FIFO not empty

## Operation
- FIFO
  - Push when i_cmd_valid & o_cmd_ready. o_cmd_ready = !full, combinational.
  - Read and write pointers carry one extra wrap bit. full = pointers equal except the wrap bit; empty = pointers fully equal.
  - No bypass: a command pushed into an empty FIFO is popped no earlier than the next edge.
  - Simultaneous push and pop on a non-full FIFO keeps the occupancy unchanged.
- Decode: slave index = addr[ADDR_WIDTH-1 -: SEL_BITS]. Index < SLAVE_COUNT gives o_psel = one-hot(index). Any other index is a decode error.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE, FIFO empty: stay; all APB outputs 0.
  - IDLE, FIFO not empty, valid index: pop; register paddr, pwrite, pwdata and one-hot psel; penable=0; go to SETUP.
  - IDLE, FIFO not empty, decode error: pop; no APB activity; next cycle o_rsp_valid=1, err=1, timeout=0, rdata=0; stay in IDLE.
  - SETUP: go to ACCESS unconditionally; penable=1; other APB outputs held; timeout counter cleared.
  - ACCESS, i_pready=0: hold every APB output stable and increment the counter.
  - ACCESS, counter reaches TIMEOUT: abort the transfer.
    - Next cycle: psel=0, penable=0.
    - o_rsp_valid=1 with err=1, timeout=1, rdata=0.
    - Go to IDLE.
  - ACCESS, i_pready=1: the transfer completes.
    - o_rsp_valid=1 next cycle; err=i_pslverr; rdata = i_prdata if read and !i_pslverr, else 0.
    - FIFO not empty with a valid index: pop and go straight to SETUP with the new command (penable=0; psel may stay high).
    - Otherwise: go to IDLE with psel=0, penable=0.
- pready is honoured only in ACCESS. i_pready in IDLE or SETUP is ignored.
  - This covers the fabric's registered pready belonging to another master's transfer.
- Exactly one response per accepted command, in command order.

## Timing
- Reset values: all o_p* signals 0, o_rsp_* 0, o_busy 0, FIFO empty, FSM in IDLE. o_cmd_ready=1 during and after reset.
- Reset asserted mid-transfer: outputs go to 0 immediately (asynchronously); queued and in-flight commands are dropped with no response.
- Latency, zero-wait slave: command pushed at edge E0 → SETUP after E1 → ACCESS after E2 → pready sampled at E3 → o_rsp_valid high for the cycle after E3.
- Latency, decode error: push at E0 → pop at E1 → o_rsp_valid after E2.
- Back-to-back transfers: 2-cycle spacing per transfer (SETUP + ACCESS) when the FIFO stays non-empty.
- A timeout in the ACCESS cycle with no pready: abort takes effect exactly TIMEOUT+1 cycles after SETUP.

## Test plan
- Reset, then one write: addr=0x4000_0010, wdata=0xA5A5_A5A5, pready high in first ACCESS → psel=3'b010; penable rises one cycle after psel; rsp_valid with err=0 after E3.
- Read from slave 2 with 3 pready-low cycles and prdata=0xDEAD_BEEF → APB outputs stable for all 4 ACCESS cycles; rsp rdata=0xDEAD_BEEF, err=0.
- Push 5 commands with zero-wait slave → o_cmd_ready low after 4 pushes; 5 responses in order; 2-cycle APB spacing.
- addr=0xC000_0000 (index 3) → no psel activity; rsp err=1, timeout=0, rdata=0.
- TIMEOUT=8, pready held low → abort with rsp err=1, timeout=1; next queued command then runs normally. A pready pulse injected during IDLE or SETUP is ignored.
- pready with pslverr=1 on a read → err=1, rdata=0; assert reset mid-ACCESS → all outputs 0 and no response.
